// File: rtl/alu_pkg.sv
// Shared ALUControl encodings and execute-unit state encoding.
// The ALU decoder imports the same codes, so both ends agree on one definition.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle combinational part of the ALU: add, sub, and, or, slt.
// Shift codes produce zero here; the execute unit handles them iteratively.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf;
  logic             lt;

  assign sum  = a + b;
  assign diff = a - b;

  // Signed less-than from the subtraction: sign of the difference, corrected by overflow.
  assign ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
  assign lt  = diff[WIDTH-1] ^ ovf;

  always_comb begin
    y = '0;
    case (alu_control)
      ALU_ADD: y = sum;
      ALU_SUB: y = diff;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, lt};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_mc.sv
// Multi-cycle ALU execute unit: single-cycle ops via alu_core, shifts one bit per
// cycle, valid/ready handshakes on both the operand and the result side.
module alu_exec_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] work, work_n;
  logic [SHW-1:0]   cnt, cnt_n;
  logic [2:0]       op_q, op_n;
  logic             sign_q, sign_n;
  logic [WIDTH-1:0] result_n;
  logic             zero_n;

  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] imm_result;
  logic [WIDTH-1:0] shift1;
  logic [SHW-1:0]   shamt;
  logic             accept;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alu_control (alu_control),
    .a           (src_a),
    .b           (src_b),
    .y           (core_y)
  );

  assign shamt     = src_b[SHW-1:0];
  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT);

  // A shift by zero completes immediately with the operand unchanged.
  assign imm_result = is_shift(alu_control) ? src_a : core_y;

  always_comb begin
    shift1 = {sign_q, work[WIDTH-1:1]};
    case (op_q)
      ALU_SLL: shift1 = {work[WIDTH-2:0], 1'b0};
      ALU_SRL: shift1 = {1'b0, work[WIDTH-1:1]};
      default: shift1 = {sign_q, work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      op_q   <= ALU_ADD;
      sign_q <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      state  <= state_n;
      work   <= work_n;
      cnt    <= cnt_n;
      op_q   <= op_n;
      sign_q <= sign_n;
      result <= result_n;
      zero   <= zero_n;
    end
  end

  // DONE behaves like IDLE once the consumer takes the result, enabling back-to-back ops.
  always_comb begin
    state_n  = state;
    work_n   = work;
    cnt_n    = cnt;
    op_n     = op_q;
    sign_n   = sign_q;
    result_n = result;
    zero_n   = zero;

    case (state)
      IDLE, DONE: begin
        if ((state == DONE) && out_ready) begin
          state_n = IDLE;
        end
        if (accept) begin
          if (is_shift(alu_control) && (shamt != '0)) begin
            state_n = SHIFT;
            work_n  = src_a;
            cnt_n   = shamt;
            op_n    = alu_control;
            sign_n  = src_a[WIDTH-1];
          end else begin
            state_n  = DONE;
            result_n = imm_result;
            zero_n   = (imm_result == '0);
          end
        end
      end
      SHIFT: begin
        work_n = shift1;
        if (cnt == CNT_ONE) begin
          state_n  = DONE;
          cnt_n    = '0;
          result_n = shift1;
          zero_n   = (shift1 == '0);
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_exec_mc.sv
// Self-checking bench for alu_exec_mc: directed vector table, handshake/reset
// corner sequences and a short random run against a behavioural reference.
module tb_alu_exec_mc;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  alu_exec_mc #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one op with out_ready=1 and measures cycles from accept to out_valid.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output logic [31:0] res, output logic z);
    int guard;
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    out_ready   = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    src_a       = ~a;
    src_b       = ~b;
    alu_control = ~op;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    z   = zero;
  endtask

  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b100:  return a << b[4:0];
      3'b110:  return a >> b[4:0];
      default: return $unsigned($signed(a) >>> b[4:0]);
    endcase
  endfunction

  initial begin
    int          lat;
    logic [31:0] res;
    logic        z;

    vecs[0]  = '{ALU_ADD, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, 1};
    vecs[1]  = '{ALU_SUB, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1};
    vecs[2]  = '{ALU_SLT, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, 1'b0, 1};
    vecs[3]  = '{ALU_SLT, 32'h00000001, 32'hFFFFFFFE, 32'h00000000, 1'b1, 1};
    vecs[4]  = '{ALU_SRA, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 5};
    vecs[5]  = '{ALU_SRL, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 5};
    vecs[6]  = '{ALU_SLL, 32'h0000ABCD, 32'hFFFFFFE0, 32'h0000ABCD, 1'b0, 1};
    vecs[7]  = '{ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1};
    vecs[8]  = '{ALU_OR,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1};
    vecs[9]  = '{ALU_SLL, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 32};
    vecs[10] = '{ALU_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1};
    vecs[11] = '{ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1};
    vecs[12] = '{ALU_SRA, 32'h7FFFFFF0, 32'h00000003, 32'h0FFFFFFE, 1'b0, 4};
    vecs[13] = '{ALU_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1};
    vecs[14] = '{ALU_SRL, 32'hFFFFFFFF, 32'h0000001F, 32'h00000001, 1'b0, 32};

    reset       = 1'b1;
    in_valid    = 1'b0;
    alu_control = 3'b000;
    src_a       = '0;
    src_b       = '0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_result",    64'(result),    64'd0);
    checkOutput("reset_zero",      64'(zero),      64'd0);
    checkOutput("reset_busy",      64'(busy),      64'd0);
    checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, z);
      checkOutput($sformatf("vec%0d_result", i),  64'(res), 64'(vecs[i].res));
      checkOutput($sformatf("vec%0d_zero", i),    64'(z),   64'(vecs[i].z));
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Shift in flight: busy, no accept; held op is taken back-to-back from DONE.
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = ALU_SRA;
    src_a       = 32'h80000000;
    src_b       = 32'h00000024;
    out_ready   = 1'b1;
    checkOutput("seqA_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    alu_control = ALU_ADD;
    src_a       = 32'd3;
    src_b       = 32'd4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("seqA_busy%0d", k),      64'(busy),      64'd1);
      checkOutput($sformatf("seqA_in_ready%0d", k),  64'(in_ready),  64'd0);
      checkOutput($sformatf("seqA_out_valid%0d", k), 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    checkOutput("seqA_done_valid",  64'(out_valid), 64'd1);
    checkOutput("seqA_done_result", 64'(result),    64'hF8000000);
    checkOutput("seqA_done_busy",   64'(busy),      64'd0);
    checkOutput("seqA_done_ready",  64'(in_ready),  64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("seqA_b2b_valid",  64'(out_valid), 64'd1);
    checkOutput("seqA_b2b_result", 64'(result),    64'd7);
    checkOutput("seqA_b2b_zero",   64'(zero),      64'd0);

    // Backpressure: result held while out_ready=0, then same-edge accept.
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = ALU_ADD;
    src_a       = 32'd5;
    src_b       = 32'd6;
    out_ready   = 1'b0;
    @(posedge clk);
    #1;
    alu_control = ALU_AND;
    src_a       = 32'hF0F0F0F0;
    src_b       = 32'hFF00FF00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("seqB_hold_valid%0d", k),  64'(out_valid), 64'd1);
      checkOutput($sformatf("seqB_hold_result%0d", k), 64'(result),    64'd11);
      checkOutput($sformatf("seqB_hold_ready%0d", k),  64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("seqB_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("seqB_next_valid",  64'(out_valid), 64'd1);
    checkOutput("seqB_next_result", 64'(result),    64'hF000F000);

    // Reset two cycles into a long shift discards it.
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = ALU_SLL;
    src_a       = 32'h00000001;
    src_b       = 32'd10;
    out_ready   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("seqC_busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("seqC_out_valid", 64'(out_valid), 64'd0);
    checkOutput("seqC_result",    64'(result),    64'd0);
    checkOutput("seqC_zero",      64'(zero),      64'd0);
    checkOutput("seqC_busy",      64'(busy),      64'd0);
    checkOutput("seqC_in_ready",  64'(in_ready),  64'd1);
    reset = 1'b0;
    applyStimulus(ALU_ADD, 32'd3, 32'd4, lat, res, z);
    checkOutput("seqC_add_result",  64'(res), 64'd7);
    checkOutput("seqC_add_latency", 64'(lat), 64'd1);

    // Random regression over all codes.
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      int          exp_lat;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      exp_res = refModel(op, a, b);
      exp_lat = (op == 3'b100 || op == 3'b110 || op == 3'b111) ? 1 + int'(b[4:0]) : 1;
      applyStimulus(op, a, b, lat, res, z);
      checkOutput($sformatf("rand%0d_op%0d_result", i, op), 64'(res), 64'(exp_res));
      checkOutput($sformatf("rand%0d_zero", i),             64'(z),   64'(exp_res == 32'd0));
      checkOutput($sformatf("rand%0d_latency", i),          64'(lat), 64'(exp_lat));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/alu_exec_mc.md
Name: alu_exec_mc

Overview:
- Multi-cycle ALU execution unit: the consumer of the 3-bit ALUControl code produced by the ALU decoder.
- Add, sub, and, or and slt complete in one cycle.
- Shifts sll, srl and sra use an iterative one-bit-per-cycle shifter.
- Sits in the execute stage of the multi-cycle core, with valid/ready handshakes on the operand side and on the result side.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from src_b.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and alu_control are valid.
- in_ready  out  1  unit can accept an operation this cycle.
- alu_control  in  3  operation code; encoding is in Behaviour.
- src_a  in  WIDTH  operand A; also the value to be shifted.
- src_b  in  WIDTH  operand B; bits [SHW-1:0] are the shift amount.
- out_valid  out  1  result and zero are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- zero  out  1  high when result == 0.
- busy  out  1  high in SHIFT state.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, busy=0, shift counter=0.
- ALUControl encoding:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 101 slt
  - 100 sll
  - 110 srl
  - 111 sra
- All eight codes are legal; there is no x output.
- Arithmetic: add/sub wrap modulo 2^WIDTH; no overflow output.
- slt: signed compare computed from (a-b) sign XOR signed overflow; result = {WIDTH-1 zeros, lt}.
- Shifts: shamt = src_b[SHW-1:0]; upper bits of src_b are ignored. srl fills with 0; sra fills with the latched src_a[WIDTH-1].
- Handshakes: a transfer occurs when valid & ready on the same edge. Operands are latched on accept; inputs may change afterwards.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready to in_ready, and it allows back-to-back operations.
- State machine IDLE / SHIFT / DONE:
  - IDLE, accept of a single-cycle op or a shift with shamt==0 -> DONE; result is registered at that edge, latency 1.
  - IDLE, accept of a shift with shamt>0 -> SHIFT; working register=src_a, counter=shamt.
  - SHIFT: each cycle shift by 1 and decrement the counter; when the counter reaches 1, the final value moves to result and the state goes to DONE. Total latency is 1+shamt cycles from accept to out_valid (e.g. shamt=4 gives out_valid 5 cycles after accept).
  - DONE: out_valid=1; result and zero are held stable while out_ready=0.
  - DONE with out_ready=1 and no new accept -> IDLE, out_valid=0.
  - DONE with out_ready=1 and in_valid=1 -> the new op is accepted on the same edge and follows the IDLE transitions (DONE again, or SHIFT).
- in_valid in SHIFT is ignored (in_ready=0); the operation is neither accepted nor lost, so the producer must hold it.
- zero is registered together with result, never computed from a stale value.
- Reset mid-SHIFT or in DONE: the pending operation is discarded and the unit returns to IDLE with the reset values above.
- shamt==WIDTH-1 is the maximum and takes WIDTH cycles of latency; the counter never wraps.

Decomposition:
- Package alu_pkg:
  - localparams ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA (3-bit).
  - State encoding IDLE/SHIFT/DONE.
  - The ALU decoder is updated to import these codes so both ends share one definition.
- One natural sub-module, alu_core: purely combinational add/sub/and/or/slt on WIDTH bits, instantiated by alu_exec_mc.
- The shifter and FSM stay in the top module.

Test Plan:
- add, a=0xFFFFFFFF, b=0x00000002 -> result 0x00000001, zero=0, out_valid 1 cycle after accept.
- sub, a=b=0x12345678 -> result 0, zero=1; then slt, a=0xFFFFFFFE (-2), b=0x00000001 -> result 1; slt with operands swapped -> result 0.
- sra, a=0x80000000, b=0x00000024 (shamt=4) -> busy for 4 cycles, in_ready=0 throughout, result 0xF8000000 with out_valid 5 cycles after accept. srl with the same operands -> 0x08000000. sll with shamt=0 -> result=a with latency 1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> result stable, in_ready=0. Then out_ready=1 with in_valid=1 (and, a=0xF0F0F0F0, b=0xFF00FF00) -> accepted on the same edge; next result 0xF000F000.
- Reset asserted 2 cycles into an sll with shamt=10 -> next cycle state IDLE, out_valid=0, result=0, in_ready=1; a following add 3+4 returns 7.
- Random regression over all 8 codes against a reference model; check latency = 1 + (shift ? shamt : 0) with out_ready=1.
